// File: rtl/bpred_pkg.sv
// Shared helpers for the BTB branch predictor.
// Index/tag extraction and counter constants, width-generic.
package bpred_pkg;

    localparam int PC_MAX_W = 64;

    // Word index: low two PC bits are byte offset and ignored.
    function automatic logic [PC_MAX_W-1:0] pc_index(
        input logic [PC_MAX_W-1:0] pc,
        input int                  idx_w
    );
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag: every PC bit above the index field.
    function automatic logic [PC_MAX_W-1:0] pc_tag(
        input logic [PC_MAX_W-1:0] pc,
        input int                  idx_w
    );
        return pc >> (idx_w + 2);
    endfunction

    // Strongly-taken counter value.
    function automatic int unsigned cnt_max_f(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    // Weakly-taken counter value used on allocation.
    function automatic int unsigned cnt_weak_f(input int cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// Saturating up/down direction counter with force-to-max.
// Pure next-state logic; the table holds the state.
module bpred_sat_ctr #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    input  logic             force_max_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Jumps pin the counter high; branches step toward their outcome.
    always_comb begin
        cnt_o = cnt_i;
        if (force_max_i) begin
            cnt_o = '1;
        end else if (inc_i) begin
            if (cnt_i != '1) cnt_o = cnt_i + 1'b1;
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_bpred.sv
// Dynamic branch predictor + BTB: IF-stage lookup, MEM-stage update.
// Build macro BPRED_STATS_EN adds saturating branch/mispredict counters.
module pipe_bpred
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic              upd_uncond,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cnt_max_f(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(cnt_weak_f(CNT_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [CNT_W-1:0]  cnt;
        logic [ADDR_W-1:0] target;
    } entry_t;

    logic              valid_q  [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    entry_t            lk_e, up_e;
    logic              up_hit;
    logic              wr_en;
    logic [CNT_W-1:0]  ctr_nxt, cnt_d;
    logic [ADDR_W-1:0] tgt_d;

    assign lk_idx = IDX_W'(pc_index(PC_MAX_W'(lk_pc), IDX_W));
    assign lk_tag = TAG_W'(pc_tag(PC_MAX_W'(lk_pc), IDX_W));
    assign up_idx = IDX_W'(pc_index(PC_MAX_W'(upd_pc), IDX_W));
    assign up_tag = TAG_W'(pc_tag(PC_MAX_W'(upd_pc), IDX_W));

    assign lk_e = '{valid_q[lk_idx], tag_q[lk_idx],
                    cnt_q[lk_idx], target_q[lk_idx]};
    assign up_e = '{valid_q[up_idx], tag_q[up_idx],
                    cnt_q[up_idx], target_q[up_idx]};

    // Lookup reads pre-edge table state; no bypass from the update port.
    always_comb begin
        pred_hit    = lk_e.valid && (lk_e.tag == lk_tag);
        pred_taken  = pred_hit && lk_e.cnt[CNT_W-1];
        pred_target = pred_taken ? lk_e.target : lk_pc + ADDR_W'(4);
    end

    assign up_hit = up_e.valid && (up_e.tag == up_tag);

    bpred_sat_ctr #(.CNT_W(CNT_W)) u_ctr (
        .cnt_i       (up_e.cnt),
        .inc_i       (upd_taken),
        .force_max_i (upd_uncond),
        .cnt_o       (ctr_nxt)
    );

    // Decide whether the resolved branch writes, and with what.
    always_comb begin
        wr_en = 1'b0;
        cnt_d = ctr_nxt;
        tgt_d = up_e.target;
        if (upd_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_taken || upd_uncond) tgt_d = upd_target;
            end else if (upd_taken || upd_uncond) begin
                wr_en = 1'b1;
                tgt_d = upd_target;
                cnt_d = upd_uncond ? CNT_MAX : CNT_WEAK_T;
            end
        end
    end

    // Valid and counter state; cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= '0;
            end
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
            cnt_q[up_idx]   <= cnt_d;
        end
    end

    // Tag and target payload; never reset, gated so reset drops the write.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= tgt_d;
        end
    end

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

`ifdef BPRED_STATS_EN
    logic [STAT_W-1:0] br_q, mp_q;

    // Saturating statistics, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            if (upd_valid && (br_q != '1)) br_q <= br_q + 1'b1;
            if (mispredict && (mp_q != '1)) mp_q <= mp_q + 1'b1;
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_pipe_bpred.sv
// Directed self-checking bench for pipe_bpred (default 64 entries).
// Statistics scenario runs only when BPRED_STATS_EN is defined.
module tb_pipe_bpred;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lk_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_uncond, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  stat_branches, stat_mispredicts;

    int nchk = 0;
    int nerr = 0;

    pipe_bpred #(.ENTRIES(64), .ADDR_W(32), .CNT_W(2), .STAT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .lk_pc            (lk_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_uncond       (upd_uncond),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt, input logic unc);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        upd_uncond      = unc;
    endtask

    task automatic idle();
        upd_valid  = 1'b0;
        upd_uncond = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input string tag,
                        input logic hit, input logic tk,
                        input logic [31:0] tgt);
        lk_pc = pc;
        #1;
        check({tag, "_hit"}, 32'(pred_hit), 32'(hit));
        check({tag, "_tk"}, 32'(pred_taken), 32'(tk));
        check({tag, "_tgt"}, pred_target, tgt);
    endtask

    initial begin
        rst = 1'b1;
        lk_pc = 32'h40;
        upd_valid = 0; upd_uncond = 0; upd_taken = 0; upd_pred_taken = 0;
        upd_pc = 0; upd_target = 0; upd_pred_target = 0;
        #12;
        look(32'h40, "rst_lk", 0, 0, 32'h44);
        check("rst_mp", 32'(mispredict), 0);
        check("rst_redir", redirect_pc, 32'h4);
        check("rst_sb", 32'(stat_branches), 0);
        check("rst_sm", 32'(stat_mispredicts), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First taken resolution at 0x40 allocates, weakly taken.
        upd(32'h40, 1, 32'h100, 0, 32'h44, 0);
        #1;
        check("alloc_mp", 32'(mispredict), 1);
        check("alloc_redir", redirect_pc, 32'h100);
        tick(); idle();
        look(32'h40, "alloc_lk", 1, 1, 32'h100);

        // Three taken: counter saturates at 3.
        upd(32'h40, 1, 32'h100, 1, 32'h100, 0);
        #1;
        check("tk_ok_mp", 32'(mispredict), 0);
        tick(); tick(); tick(); idle();

        // Not-taken steps: 3->2 still taken, 2->1 not taken.
        upd(32'h40, 0, 32'h100, 1, 32'h100, 0);
        #1;
        check("nt1_mp", 32'(mispredict), 1);
        check("nt1_redir", redirect_pc, 32'h44);
        tick(); idle();
        look(32'h40, "nt1_lk", 1, 1, 32'h100);
        upd(32'h40, 0, 32'h100, 1, 32'h100, 0);
        tick(); idle();
        look(32'h40, "nt2_lk", 1, 0, 32'h44);
        upd(32'h40, 0, 32'h100, 1, 32'h100, 0);
        #1;
        check("nt3_mp", 32'(mispredict), 1);
        check("nt3_redir", redirect_pc, 32'h44);
        tick();
        upd(32'h40, 0, 32'h100, 0, 32'h44, 0);
        #1;
        check("nt4_mp", 32'(mispredict), 0);
        tick(); idle();
        // Counter held at 0; one taken -> 1, still not taken.
        upd(32'h40, 1, 32'h100, 1, 32'h104, 0);
        #1;
        check("tgt_mp", 32'(mispredict), 1);
        check("tgt_redir", redirect_pc, 32'h100);
        tick(); idle();
        look(32'h40, "sat0_lk", 1, 0, 32'h44);

        // Alias 0x140 replaces entry of 0x40.
        upd(32'h140, 1, 32'h200, 0, 32'h144, 0);
        tick(); idle();
        look(32'h40, "alias_old", 0, 0, 32'h44);
        look(32'h140, "alias_new", 1, 1, 32'h200);

        // Same-cycle lookup/update: no bypass.
        upd(32'h80, 1, 32'h300, 0, 32'h84, 0);
        look(32'h80, "same_pre", 0, 0, 32'h84);
        tick(); idle();
        look(32'h80, "same_post", 1, 1, 32'h300);

        // Miss and not-taken writes nothing.
        upd(32'hC0, 0, 32'h900, 0, 32'hC4, 0);
        tick(); idle();
        look(32'hC0, "nt_miss", 0, 0, 32'hC4);

        // Jump forces max; one not-taken leaves it taken.
        upd(32'h100, 1, 32'h400, 0, 32'h104, 1);
        tick(); idle();
        upd(32'h100, 0, 32'h400, 1, 32'h400, 0);
        tick(); idle();
        look(32'h100, "jmp_lk", 1, 1, 32'h400);

        // Reset during an update drops the write and clears table.
        upd(32'h180, 1, 32'h500, 0, 32'h184, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; idle();
        look(32'h180, "rstw_lk", 0, 0, 32'h184);
        look(32'h140, "rstclr_lk", 0, 0, 32'h144);

        // First edge after reset updates normally; low PC bits ignored.
        upd(32'h180, 1, 32'h500, 0, 32'h184, 0);
        tick(); idle();
        look(32'h182, "post_rst", 1, 1, 32'h500);

        // PC wrap-around.
        look(32'hFFFF_FFFC, "wrap_lk", 0, 0, 32'h0);
        upd(32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 0);
        #1;
        check("wrap_redir", redirect_pc, 32'h0);
        tick(); idle();

`ifdef BPRED_STATS_EN
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            upd(32'h200, 0, 32'h0, (i < 5), 32'h0, 0);
            tick();
        end
        idle();
        #1;
        check("st_br", 32'(stat_branches), 15);
        check("st_mp", 32'(stat_mispredicts), 5);
        rst = 1'b1;
        #1;
        check("st_br_rst", 32'(stat_branches), 0);
        check("st_mp_rst", 32'(stat_mispredicts), 0);
        rst = 1'b0;
`else
        check("nost_br", 32'(stat_branches), 0);
        check("nost_mp", 32'(stat_mispredicts), 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pipe_bpred.md
Name: pipe_bpred

Overview:
- Dynamic branch predictor and branch target buffer (BTB) for the five-stage MIPS pipeline.
- Replaces static not-taken fetch. The IF stage looks up the current PC combinationally and gets a taken/not-taken prediction plus a target.
- The MEM stage, where branches resolve, writes the outcome back. The block also flags mispredicts and supplies the redirect PC used to flush stages 1-3.

Parameters:
- ENTRIES, 64, number of table entries; power of two, minimum 4.
- ADDR_W, 32, PC width.
- CNT_W, 2, saturating-counter width; minimum 1.
- STAT_W, 32, width of each statistics counter (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- lk_pc  in  ADDR_W  IF-stage PC.
- pred_hit  out  1  lookup matches a valid entry.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted target; equals lk_pc+4 when not predicted taken.
- upd_valid  in  1  a branch or jump resolves this cycle.
- upd_uncond  in  1  resolved instruction is a jump.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipeline.
- upd_pred_target  in  ADDR_W  predicted target carried down the pipeline.
- mispredict  out  1  flush request.
- redirect_pc  out  ADDR_W  correct next PC.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

Behaviour:
- Indexing:
  - IDX_W = log2(ENTRIES); idx = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
  - Entry fields: valid, tag, cnt[CNT_W-1:0], target[ADDR_W-1:0].
- Lookup (combinational, zero latency):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && cnt MSB.
  - pred_target = pred_taken ? target : lk_pc+4.
- Update (registered on posedge clk when upd_valid):
  - Hit: taken increments cnt, saturating at 2^CNT_W-1; not-taken decrements, saturating at 0. target is written with upd_target when taken.
  - Miss and taken: allocate the entry (replacing any occupant), valid=1, new tag, target=upd_target, cnt=2^(CNT_W-1) (weakly taken).
  - Miss and not-taken: no write.
  - upd_uncond=1: cnt forced to max, target written, allocation as for taken.
- Simultaneous lookup and update to the same index: lookup returns pre-edge contents; no bypass. The new value is visible from the next cycle.
- Mispredict (combinational):
  - mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect_pc is valid only while mispredict=1 and is don't-care otherwise.
- Reset:
  - All valid bits, cnt fields and statistics clear to 0 asynchronously. target is not reset.
  - Consequently every output is 0 during reset except pred_target = lk_pc+4 and redirect_pc = upd_pc+4.
  - Reset asserted mid-update: the write is discarded.
  - First posedge after deassertion: normal update.
- Arithmetic: all PC adds are ADDR_W-bit modulo; wrap-around at 2^ADDR_W is permitted.
- Address alignment: the low two PC bits are ignored for index and tag.

Optional Feature:
- Macro: BPRED_STATS_EN.
- Defined:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments on every mispredict.
  - Both saturate at 2^STAT_W-1; both are cleared only by rst.
- Undefined: both ports are tied to 0 and no counter flops are built. Ports exist in both builds.

Decomposition:
- Shared package bpred_pkg:
  - Entry struct (valid, tag, cnt, target).
  - Counter constants CNT_MAX and CNT_WEAK_T.
  - Index/tag extraction functions.
- Natural sub-module: bpred_sat_ctr, the CNT_W-bit saturating up/down counter with force-max. It is instantiated as next-state logic per entry update.

Test Plan:
- Reset, then lk_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; both stats 0.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle lookup 0x40 -> hit, taken, target 0x100, cnt=2.
- Three further taken updates at 0x40 -> cnt saturates at 3. Three not-taken updates -> cnt=0, pred_taken=0 at lookup, and each not-taken resolution that the carried prediction had as taken asserts mispredict with redirect_pc=0x44.
- Alias: pc=0x40 and pc=0x40+4*ENTRIES (0x140 with defaults), the latter taken to target 0x200 -> entry replaced. Lookup 0x40 now misses; lookup 0x140 hits, target 0x200.
- Same-cycle lookup and update at 0x80 (first taken, target 0x300) -> that cycle pred_hit=0; following cycle pred_hit=1, pred_target=0x300.
- With BPRED_STATS_EN and STAT_W=4: 20 updates, 5 mispredicted -> stat_branches=15 (saturated), stat_mispredicts=5. Assert rst mid-sequence -> both 0 immediately, without waiting for a clock edge.
